pipelined_control_unit: RTL

//  RV32I(M) control path for the 5-stage pipeline. Decodes the IF/ID instruction fields and

---
 rtl/pipelined_control_unit_pkg.sv | 63 ++++++
 rtl/pipelined_control_unit_decode.sv | 93 +++++++++
 rtl/pipelined_control_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_pkg.sv
// Shared encodings for the pipelined RV32I(M) control path: opcodes, ALU codes,
// immediate/writeback selects, multi-cycle FSM states and the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL    = 5'd2,  ALU_SLT   = 5'd3,
        ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA   = 5'd7,
        ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_PASSB  = 5'd10,
        ALU_MUL  = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
        ALU_DIV  = 5'd20, ALU_DIVU = 5'd21, ALU_REM    = 5'd22, ALU_REMU  = 5'd23
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_sel_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2} mem_to_reg_e;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mc_state_e;

    typedef struct packed {
        alu_op_e     alu_control;
        logic        operand_a;
        logic        operand_b;
        logic        branch;
        logic        next_sel;
        logic        mem_load;
        logic        mem_store;
        logic        reg_write;
        mem_to_reg_e mem_to_reg;
        logic        is_mc;
    } ctrl_bundle_t;

    function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // DIV/DIVU/REM/REMU occupy codes 20..23, MUL family 16..19.
    function automatic logic is_div(input alu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/pipelined_control_unit_decode.sv
// Combinational RV32I(M) decoder: opcode/fun3/fun7 to control bundle, immediate
// select, illegal flag and multi-cycle marker.
module rv_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0]   opcode_i,
    input  logic [2:0]   fun3_i,
    input  logic [6:0]   fun7_i,
    output ctrl_bundle_t ctrl_o,
    output imm_sel_e     imm_sel_o,
    output logic         illegal_o,
    output logic         is_mc_o
);

    always_comb begin
        ctrl_o    = '0;
        imm_sel_o = IMM_I;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_LUI: begin
                imm_sel_o = IMM_U;
                ctrl_o.alu_control = ALU_PASSB;
                ctrl_o.operand_b = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel_o = IMM_U;
                ctrl_o.operand_a = 1'b1;
                ctrl_o.operand_b = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                imm_sel_o = (opcode_i == OPC_JAL) ? IMM_J : IMM_I;
                ctrl_o.operand_a  = (opcode_i == OPC_JAL);
                ctrl_o.operand_b  = 1'b1;
                ctrl_o.next_sel   = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = WB_PC4;
                illegal_o = (opcode_i == OPC_JALR) && (fun3_i != 3'b000);
            end
            OPC_BRANCH: begin
                imm_sel_o = IMM_B;
                ctrl_o.branch = 1'b1;
                case (fun3_i[2:1])
                    2'b00:   ctrl_o.alu_control = ALU_SUB;
                    2'b10:   ctrl_o.alu_control = ALU_SLT;
                    2'b11:   ctrl_o.alu_control = ALU_SLTU;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl_o.operand_b  = 1'b1;
                ctrl_o.mem_load   = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = WB_LOAD;
                illegal_o = (fun3_i == 3'b011) || (fun3_i[2:1] == 2'b11);
            end
            OPC_STORE: begin
                imm_sel_o = IMM_S;
                ctrl_o.operand_b = 1'b1;
                ctrl_o.mem_store = 1'b1;
                illegal_o = fun3_i[2] || (fun3_i[1:0] == 2'b11);
            end
            OPC_OPIMM: begin
                ctrl_o.operand_b   = 1'b1;
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.alu_control = base_alu(fun3_i, (fun3_i == 3'b101) && fun7_i[5]);
                illegal_o = ((fun3_i == 3'b001) && (fun7_i != F7_BASE)) ||
                            ((fun3_i == 3'b101) && (fun7_i != F7_BASE) && (fun7_i != F7_ALT));
            end
            OPC_OP: begin
                ctrl_o.reg_write = 1'b1;
                if (ENABLE_M && fun7_i == F7_MULDIV) begin
                    ctrl_o.alu_control = alu_op_e'({2'b10, fun3_i});
                    ctrl_o.is_mc = 1'b1;
                end else if (fun7_i == F7_BASE) begin
                    ctrl_o.alu_control = base_alu(fun3_i, 1'b0);
                end else if (fun7_i == F7_ALT && (fun3_i == 3'b000 || fun3_i == 3'b101)) begin
                    ctrl_o.alu_control = base_alu(fun3_i, 1'b1);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_FENCE: ;
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) ctrl_o = '0;
        is_mc_o = ctrl_o.is_mc;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX/MEM/WB control-path stage registers with bubble insertion, flush, and a
// counter FSM that holds EX for multi-cycle MUL/DIV.
module pipelined_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] fun3,
    input  logic [6:0] fun7,
    input  logic [4:0] id_rd,
    input  logic       stall_in,
    input  logic       flush,
    output logic [2:0] id_imm_sel,
    output logic       id_illegal,
    output logic       id_ready,
    output logic       mc_busy,
    output logic       ex_valid,
    output logic [4:0] ex_alu_control,
    output logic       ex_operand_a,
    output logic       ex_operand_b,
    output logic       ex_branch,
    output logic       ex_next_sel,
    output logic [4:0] ex_rd,
    output logic       mem_valid,
    output logic       mem_load,
    output logic       mem_store,
    output logic       mem_en,
    output logic [2:0] mem_fun3,
    output logic [4:0] mem_rd,
    output logic       wb_reg_write,
    output logic [1:0] wb_mem_to_reg,
    output logic [4:0] wb_rd
);

    localparam int unsigned MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = (MAX_L < 2) ? 1 : $clog2(MAX_L);

    ctrl_bundle_t id_ctrl;
    imm_sel_e     id_imm;
    logic         id_bad, id_is_mc, id_accept;

    rv_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .opcode_i (opcode),
        .fun3_i   (fun3),
        .fun7_i   (fun7),
        .ctrl_o   (id_ctrl),
        .imm_sel_o(id_imm),
        .illegal_o(id_bad),
        .is_mc_o  (id_is_mc)
    );

    ctrl_bundle_t ex_ctrl_q, ex_ctrl_d;
    logic         ex_valid_q, ex_valid_d;
    logic [4:0]   ex_rd_q, ex_rd_d;
    logic [2:0]   ex_fun3_q, ex_fun3_d;
    logic         mem_valid_q, mem_valid_d, mem_load_q, mem_load_d, mem_store_q, mem_store_d;
    logic         mem_rw_q, mem_rw_d;
    mem_to_reg_e  mem_m2r_q, mem_m2r_d;
    logic [2:0]   mem_fun3_q, mem_fun3_d;
    logic [4:0]   mem_rd_q, mem_rd_d;
    logic         wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
    mem_to_reg_e  wb_m2r_q, wb_m2r_d;
    logic [4:0]   wb_rd_q, wb_rd_d;
    mc_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    int unsigned  ex_lat;
    logic         mc_start;

    assign id_accept = id_valid && !id_bad;
    assign ex_lat    = !ex_ctrl_q.is_mc ? 1 : (is_div(ex_ctrl_q.alu_control) ? DIV_CYCLES : MUL_CYCLES);
    assign mc_start  = (state_q == IDLE) && ex_valid_q && ex_ctrl_q.is_mc && (ex_lat > 1);
    assign mc_busy   = mc_start || (state_q == BUSY);

    // Counter loads L-2 and leaves BUSY when it would step past 1, giving L-1 busy cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (mc_start) begin
                    if (ex_lat == 2) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(ex_lat - 2);
                    end
                end
                BUSY: if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        ex_fun3_d  = ex_fun3_q;
        if (flush || (!mc_busy && stall_in)) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_rd_d    = '0;
            ex_fun3_d  = '0;
        end else if (!mc_busy) begin
            ex_valid_d = id_accept;
            ex_ctrl_d  = id_accept ? id_ctrl : '0;
            ex_rd_d    = id_accept ? id_rd : '0;
            ex_fun3_d  = id_accept ? fun3 : '0;
        end
        // An op still busy in EX never reaches MEM, even when a flush aborts it.
        mem_valid_d = !mc_busy && ex_valid_q;
        mem_load_d  = !mc_busy && ex_ctrl_q.mem_load;
        mem_store_d = !mc_busy && ex_ctrl_q.mem_store;
        mem_rw_d    = !mc_busy && ex_ctrl_q.reg_write;
        mem_m2r_d   = mc_busy ? WB_ALU : ex_ctrl_q.mem_to_reg;
        mem_fun3_d  = mc_busy ? '0 : ex_fun3_q;
        mem_rd_d    = mc_busy ? '0 : ex_rd_q;
        wb_valid_d  = mem_valid_q;
        wb_rw_d     = mem_rw_q;
        wb_m2r_d    = mem_m2r_q;
        wb_rd_d     = mem_rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            ex_fun3_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_m2r_q   <= WB_ALU;
            mem_fun3_q  <= '0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_m2r_q    <= WB_ALU;
            wb_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            ex_fun3_q   <= ex_fun3_d;
            mem_valid_q <= mem_valid_d;
            mem_load_q  <= mem_load_d;
            mem_store_q <= mem_store_d;
            mem_rw_q    <= mem_rw_d;
            mem_m2r_q   <= mem_m2r_d;
            mem_fun3_q  <= mem_fun3_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rw_q     <= wb_rw_d;
            wb_m2r_q    <= wb_m2r_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    assign id_imm_sel     = id_imm;
    assign id_illegal     = id_valid && id_bad;
    assign id_ready       = !stall_in && !mc_busy;
    assign ex_valid       = ex_valid_q;
    assign ex_alu_control = ex_ctrl_q.alu_control;
    assign ex_operand_a   = ex_ctrl_q.operand_a;
    assign ex_operand_b   = ex_ctrl_q.operand_b;
    assign ex_branch      = ex_ctrl_q.branch;
    assign ex_next_sel    = ex_ctrl_q.next_sel;
    assign ex_rd          = ex_rd_q;
    assign mem_valid      = mem_valid_q;
    assign mem_load       = mem_load_q;
    assign mem_store      = mem_store_q;
    assign mem_en         = mem_load_q || mem_store_q;
    assign mem_fun3       = mem_fun3_q;
    assign mem_rd         = mem_rd_q;
    assign wb_reg_write   = wb_valid_q && wb_rw_q && (wb_rd_q != '0);
    assign wb_mem_to_reg  = wb_m2r_q;
    assign wb_rd          = wb_rd_q;

endmodule
